// File: rtl/apu_cfg_arbiter.sv
// -----------------------------------------------------------------------------
// apu_cfg_arbiter
//
// Purpose: arbitrates config-register writes from two requesters (host and
// sequencer) into a small write queue. Queued writes are committed to the
// config file only at sample boundaries. Up to MAX_BURST writes are committed
// per sample_tick, one per cycle, through a registered write port.
//
// Handshake: a request transfers on any rising edge where reqN_valid and
// reqN_ready are both high. Ready depends on the valids and on the queue
// state, and never feeds back into the grant. At most one transfer per cycle.
//
// Parameters:
//   FIFO_DEPTH  write-queue entries (power of two, >= 2)
//   MAX_BURST   max writes committed per sample boundary (>= 1)
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   sample_tick       pulse on the last cycle of each sample period
//   req0_*            host requester       (valid/ready, addr, data, be)
//   req1_*            sequencer requester  (valid/ready, addr, data, be)
//   cfg_we            byte enables of the committed write (0 = no write)
//   cfg_w_addr/data   committed write address/data (hold between writes)
//   busy              high while the drain FSM is in DRAIN (FSM state view)
//   fifo_count        current queue occupancy
//
// Build option:
//   APU_CFG_FIXED_PRIO_EN  defined   -> requester 0 always wins a tie
//                          undefined -> round-robin on ties (default)
// -----------------------------------------------------------------------------
module apu_cfg_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sample_tick,
    input  logic                          req0_valid,
    output logic                          req0_ready,
    input  logic [2:0]                    req0_addr,
    input  logic [15:0]                   req0_data,
    input  logic [1:0]                    req0_be,
    input  logic                          req1_valid,
    output logic                          req1_ready,
    input  logic [2:0]                    req1_addr,
    input  logic [15:0]                   req1_data,
    input  logic [1:0]                    req1_be,
    output logic [1:0]                    cfg_we,
    output logic [2:0]                    cfg_w_addr,
    output logic [15:0]                   cfg_w_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int EW = 21;  // {addr[2:0], data[15:0], be[1:0]}

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [BW-1:0]   burst_q;
    logic [EW-1:0]   mem [FIFO_DEPTH];

    logic            full, empty;
    logic            prefer0;
    logic            grant0, grant1;
    logic            acc0, acc1, push, pop;
    logic            last_pop, burst_hit;
    logic [EW-1:0]   push_entry, head;

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);

    // ---------------------------------------------------------------- arbiter
`ifdef APU_CFG_FIXED_PRIO_EN
    assign prefer0 = 1'b1;
`else
    // High when requester 1 took the most recent transfer, so requester 0
    // is favoured on the next tie.
    logic last_grant_q;
    assign prefer0 = last_grant_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (acc0) begin
            last_grant_q <= 1'b0;
        end else if (acc1) begin
            last_grant_q <= 1'b1;
        end
    end
`endif

    // Grant is a function of the valids and the tie-break only; readiness
    // additionally requires queue space and reset being released.
    assign grant0     = req0_valid && (!req1_valid || prefer0);
    assign grant1     = req1_valid && (!req0_valid || !prefer0);
    assign req0_ready = !reset && !full && grant0;
    assign req1_ready = !reset && !full && grant1;
    assign acc0       = req0_valid && req0_ready;
    assign acc1       = req1_valid && req1_ready;
    assign push       = acc0 || acc1;
    assign push_entry = acc0 ? {req0_addr, req0_data, req0_be}
                             : {req1_addr, req1_data, req1_be};

    // ------------------------------------------------------------------ queue
    assign pop  = (state_q == DRAIN) && !empty;
    assign head = mem[rd_ptr_q];

    // Storage carries no reset: entries are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // ------------------------------------------------------------- drain FSM
    // A pop only empties the queue if nothing is pushed in the same cycle.
    assign last_pop  = (count_q == CW'(1)) && !push;
    assign burst_hit = (burst_q == BW'(MAX_BURST - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sample_tick && !empty)          state_d = DRAIN;
            DRAIN:   if (pop && (last_pop || burst_hit)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == DRAIN);
    end

    // Held at zero while idle so every burst starts counting from zero.
    always_ff @(posedge clk) begin
        if (reset || (state_q == IDLE)) begin
            burst_q <= '0;
        end else if (pop) begin
            burst_q <= burst_q + BW'(1);
        end
    end

    // ------------------------------------------------------ cfg write port
    // Address/data hold between pops; a be=00 entry still updates them.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_we     <= '0;
            cfg_w_addr <= '0;
            cfg_w_data <= '0;
        end else if (pop) begin
            cfg_we     <= head[1:0];
            cfg_w_addr <= head[20:18];
            cfg_w_data <= head[17:2];
        end else begin
            cfg_we     <= '0;
        end
    end

    assign fifo_count = count_q;

endmodule

// File: tb/tb_apu_cfg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apu_cfg_arbiter
//
// Drives apu_cfg_arbiter (FIFO_DEPTH=8, MAX_BURST=4) with directed sequences
// and a randomized phase. A queue-based reference model predicts readies,
// occupancy, busy and every committed write; predicted writes go into exp_q
// tagged with the cycle they must appear, and an independent monitor compares
// the write port against that queue every cycle.
// -----------------------------------------------------------------------------
module tb_apu_cfg_arbiter;

    localparam int DEPTH = 8;
    localparam int BURST = 4;

    // ------------------------------------------------------ clock / reset
    logic        clk;
    logic        reset;
    logic        sample_tick;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_addr, req1_addr;
    logic [15:0] req0_data, req1_data;
    logic [1:0]  req0_be, req1_be;
    logic [1:0]  cfg_we;
    logic [2:0]  cfg_w_addr;
    logic [15:0] cfg_w_data;
    logic        busy;
    logic [3:0]  fifo_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    apu_cfg_arbiter #(.FIFO_DEPTH(DEPTH), .MAX_BURST(BURST)) dut (
        .clk        (clk),
        .reset      (reset),
        .sample_tick(sample_tick),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_be    (req0_be),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_be    (req1_be),
        .cfg_we     (cfg_we),
        .cfg_w_addr (cfg_w_addr),
        .cfg_w_data (cfg_w_data),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    // ------------------------------------------------------------ checking
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        else
            n_pass++;
    endtask

    // Expected write: {due_cycle[31:0], we[1:0], addr[2:0], data[15:0]}
    logic [52:0] exp_q[$];

    // -------------------------------------------------------- reference model
    // Queue of pending writes {addr, data, be}, a draining flag, the number of
    // writes committed in the current burst, and who won the latest transfer.
    logic [20:0] mq[$];
    bit          m_drain = 1'b0;
    int          m_burst = 0;
    bit          m_last1 = 1'b1;

    task automatic model_cycle();
        int  sz;
        bit  pref0, g0, g1, e_r0, e_r1, pop;
        logic [20:0] e;
        sz = mq.size();
`ifdef APU_CFG_FIXED_PRIO_EN
        pref0 = 1'b1;
`else
        pref0 = m_last1;
`endif
        g0   = req0_valid && (!req1_valid || pref0);
        g1   = req1_valid && (!req0_valid || !pref0);
        e_r0 = !reset && (sz < DEPTH) && g0;
        e_r1 = !reset && (sz < DEPTH) && g1;

        check("req0_ready", 32'(req0_ready), 32'(e_r0));
        check("req1_ready", 32'(req1_ready), 32'(e_r1));
        check("fifo_count", 32'(fifo_count), 32'(sz));
        check("busy",       32'(busy),       32'(m_drain));

        if (reset) begin
            mq.delete();
            m_drain = 1'b0;
            m_burst = 0;
            m_last1 = 1'b1;
        end else begin
            pop = m_drain && (sz > 0);
            if (pop) begin
                e = mq.pop_front();
                exp_q.push_back({32'(cyc + 1), e[1:0], e[20:18], e[17:2]});
            end
            if (e_r0) begin
                mq.push_back({req0_addr, req0_data, req0_be});
                m_last1 = 1'b0;
            end else if (e_r1) begin
                mq.push_back({req1_addr, req1_data, req1_be});
                m_last1 = 1'b1;
            end
            if (m_drain) begin
                if (pop) m_burst++;
                if (mq.size() == 0 || m_burst == BURST) m_drain = 1'b0;
            end else if (sample_tick && sz > 0) begin
                m_drain = 1'b1;
                m_burst = 0;
            end
        end
    endtask

    // -------------------------------------------------------------- monitor
    logic [2:0]  hold_addr = '0;
    logic [15:0] hold_data = '0;
    bit          rst_prev  = 1'b1;

    always @(negedge clk) begin
        logic [52:0] e;
        if (rst_prev) begin
            hold_addr = '0;
            hold_data = '0;
        end
        while (exp_q.size() > 0 && int'(exp_q[0][52:21]) < cyc) begin
            e = exp_q.pop_front();
            check("missed_write_cycle", 32'(cyc), e[52:21]);
        end
        if (exp_q.size() > 0 && int'(exp_q[0][52:21]) == cyc) begin
            e = exp_q.pop_front();
            check("cfg_we",     32'(cfg_we),     32'(e[20:19]));
            check("cfg_w_addr", 32'(cfg_w_addr), 32'(e[18:16]));
            check("cfg_w_data", 32'(cfg_w_data), 32'(e[15:0]));
            hold_addr = e[18:16];
            hold_data = e[15:0];
        end else begin
            check("idle_cfg_we",   32'(cfg_we),     32'd0);
            check("hold_cfg_addr", 32'(cfg_w_addr), 32'(hold_addr));
            check("hold_cfg_data", 32'(cfg_w_data), 32'(hold_data));
        end
        rst_prev = reset;
    end

    // -------------------------------------------------------------- drivers
    task automatic set_in(input bit rst, input bit v0, input bit v1,
                          input bit tk);
        reset       = rst;
        req0_valid  = v0;
        req1_valid  = v1;
        sample_tick = tk;
        req0_addr   = 3'($urandom_range(0, 7));
        req1_addr   = 3'($urandom_range(0, 7));
        req0_data   = 16'($urandom_range(0, 65535));
        req1_data   = 16'($urandom_range(0, 65535));
        req0_be     = 2'($urandom_range(0, 3));
        req1_be     = 2'($urandom_range(0, 3));
    endtask

    // Inputs are set just after a rising edge; the model samples mid-cycle.
    task automatic run_cycle();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(0, 0, 0, 0);
            run_cycle();
        end
    endtask

    task automatic tick_once();
        set_in(0, 0, 0, 1);
        run_cycle();
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        set_in(1, 0, 0, 0);
        repeat (3) run_cycle();

        // Single host write committed two cycles after the tick.
        set_in(0, 1, 0, 0);
        req0_addr = 3'd2;
        req0_data = 16'h1234;
        req0_be   = 2'b11;
        run_cycle();
        idle(1);
        tick_once();
        idle(4);

        // Tick with an empty queue does nothing.
        tick_once();
        idle(3);

        // Both requesters valid from reset, then fill the queue to full.
        set_in(1, 0, 0, 0);
        run_cycle();
        for (int i = 0; i < 10; i++) begin
            set_in(0, 1, 1, 0);
            run_cycle();
        end

        // Full queue: host keeps pushing across the tick and the drain.
        set_in(0, 1, 0, 1);
        run_cycle();
        for (int i = 0; i < 6; i++) begin
            set_in(0, 1, 0, 0);
            run_cycle();
        end
        idle(2);
        repeat (3) begin
            tick_once();
            idle(6);
        end

        // Six entries: burst of four, then the remaining two.
        set_in(1, 0, 0, 0);
        run_cycle();
        for (int i = 0; i < 6; i++) begin
            set_in(0, i % 2 == 0, i % 2 == 1, 0);
            run_cycle();
        end
        tick_once();
        idle(8);
        tick_once();
        idle(6);

        // Reset on the second DRAIN cycle discards the queued entries.
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 0, 0);
            run_cycle();
        end
        tick_once();
        idle(1);
        set_in(1, 0, 0, 0);
        run_cycle();
        idle(2);
        tick_once();
        idle(4);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            set_in($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0);
            run_cycle();
        end

        // Flush anything still queued.
        repeat (4) begin
            tick_once();
            idle(6);
        end
        idle(2);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
